data_mem_arbiter: RTL

Two-port arbiter for the single-ported data memory in the MIPS pipeline. It shares the memory between the MEM stage (CPU port) and a loader/debug DMA port. The CPU has fixed priority, and a starvation guard forces one DMA slot after a bounded wait. The block sits between the EX/MEM register outputs and the data memory, and drives the pipeline stall line when the CPU loses a slot.

---
 rtl/mips_pkg.sv | 10 +
 rtl/starve_counter.sv | 28 ++
 rtl/data_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline data-memory path.
package mips_pkg;

  typedef enum logic {ARB_NORMAL, ARB_STARVE} arb_state_t;

  localparam int DEF_MAX_WAIT = 8;
  localparam int MEM_IDX_LSB  = 2;
  localparam int MEM_IDX_MSB  = 9;

endpackage

// File: rtl/starve_counter.sv
// Saturating 8-bit count of consecutive denied DMA cycles with a terminal flag.
module starve_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam logic [7:0] TERM_VAL = 8'(MAX_WAIT - 1);

  logic [7:0] wcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (clr) begin
      wcnt <= '0;
    end else if (inc && (wcnt != 8'hFF)) begin
      wcnt <= wcnt + 8'd1;
    end
  end

  assign term = (wcnt == TERM_VAL);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (fixed priority)
// and a DMA port, with a starvation guard that forces one DMA slot.
module data_mem_arbiter import mips_pkg::*; #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t state, state_nxt;
  logic cpu_act, cpu_own, dma_own;
  logic cnt_clr, cnt_inc, cnt_term;

  assign cpu_act = cpu_mem_read | cpu_mem_write;

  starve_counter #(.MAX_WAIT(MAX_WAIT)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    cpu_own   = 1'b0;
    dma_own   = 1'b0;
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;

    if ((state == ARB_STARVE) && dma_req) begin
      dma_own = 1'b1;
    end else if (cpu_act) begin
      cpu_own = 1'b1;
    end else if (dma_req) begin
      dma_own = 1'b1;
    end

    if (!dma_req || dma_own) begin
      state_nxt = ARB_NORMAL;
      cnt_clr   = 1'b1;
    end else if (state == ARB_NORMAL) begin
      if (cnt_term) begin
        state_nxt = ARB_STARVE;
        cnt_clr   = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  // A simultaneous load+store from the CPU is treated as a store.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_own) begin
      mem_write = cpu_mem_write;
      mem_read  = cpu_mem_read & ~cpu_mem_write;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_own) begin
      mem_write = dma_we;
      mem_read  = ~dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  assign cpu_rdata = (cpu_own && mem_read) ? mem_rdata : '0;
  assign cpu_stall = cpu_act & ~cpu_own;
  assign dma_gnt   = dma_own;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      dma_rvalid <= dma_own & ~dma_we;
      if (dma_own && !dma_we) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule
